// File: rtl/axi_delayer_cfg.sv
// Runtime-programmable AXI4 channel delayer.
// Each of the five channels can run in bypass, fixed-delay or LFSR-random mode.
// A one-beat holding stage sits on each channel.

package axi_delayer_cfg_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'd0,
        MODE_FIXED      = 2'd1,
        MODE_RANDOM     = 2'd2,
        MODE_BYPASS_ALT = 2'd3
    } mode_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;

endpackage

// One channel: a single holding stage with a load-and-count-down delay.
module axi_delayer_cfg_stage #(
    parameter type         data_t     = logic,
    parameter int unsigned DelayWidth = 4,
    parameter logic [15:0] Seed       = 16'h0001
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode,
    input  logic [DelayWidth-1:0] delay,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  data_t                 in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output data_t                 out_data,
    output logic                  busy
);
    import axi_delayer_cfg_pkg::*;

    logic                  full_q;
    logic [DelayWidth-1:0] cnt_q;
    logic [15:0]           lfsr_q;
    data_t                 data_q;

    logic                  bypass;
    logic                  pass;
    logic                  held_valid;
    logic                  capture;
    logic                  drain;
    logic [DelayWidth-1:0] rnd;
    logic [DelayWidth-1:0] load_delay;
    logic [15:0]           lfsr_next;

    assign bypass     = (mode == MODE_BYPASS) || (mode == MODE_BYPASS_ALT);
    // A bypass request only becomes a wire once the held beat has left.
    assign pass       = bypass && !full_q;
    assign held_valid = full_q && (cnt_q == '0);
    assign rnd        = lfsr_q[DelayWidth-1:0];
    assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Handshake routing: direct wires in bypass, stage-driven otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = data_q;
        if (pass) begin
            in_ready  = out_ready;
            out_valid = in_valid & rst_ni;
            out_data  = in_data;
        end else begin
            // A full stage in bypass mode refuses new beats until it drains.
            in_ready  = !bypass && (!full_q || (held_valid && out_ready));
            out_valid = held_valid;
        end
    end

    assign capture = !pass && in_valid && in_ready;
    assign drain   = !pass && held_valid && out_ready;

    // Delay chosen at capture: the fixed value, or the LFSR clamped to the bound.
    always_comb begin
        load_delay = delay;
        if (mode == MODE_RANDOM) begin
            load_delay = (rnd > delay) ? delay : rnd;
        end
    end

    // Occupancy, countdown and LFSR state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            cnt_q  <= '0;
            lfsr_q <= Seed;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            if (capture) begin
                full_q <= 1'b1;
                cnt_q  <= load_delay;
            end else begin
                if (drain) begin
                    full_q <= 1'b0;
                end
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if (capture && (mode == MODE_RANDOM)) begin
                lfsr_q <= lfsr_next;
            end
        end
    end

    // Payload register, loaded on capture.
    always_ff @(posedge clk_i) begin
        // NOTE: payload is not reset; full_q alone decides whether it is meaningful.
        if (capture) begin
            data_q <= in_data;
        end
    end

    assign busy = full_q;

endmodule

// Top level: five independent channel stages between slv and mst ports.
module axi_delayer_cfg #(
    parameter type         aw_chan_t  = axi_delayer_cfg_pkg::aw_chan_t,
    parameter type         w_chan_t   = axi_delayer_cfg_pkg::w_chan_t,
    parameter type         b_chan_t   = axi_delayer_cfg_pkg::b_chan_t,
    parameter type         ar_chan_t  = axi_delayer_cfg_pkg::ar_chan_t,
    parameter type         r_chan_t   = axi_delayer_cfg_pkg::r_chan_t,
    parameter type         req_t      = axi_delayer_cfg_pkg::req_t,
    parameter type         resp_t     = axi_delayer_cfg_pkg::resp_t,
    parameter int unsigned DelayWidth = 4,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [4:0][1:0]            cfg_mode_i,
    input  logic [4:0][DelayWidth-1:0] cfg_delay_i,
    input  req_t                       slv_req_i,
    output resp_t                      slv_resp_o,
    output req_t                       mst_req_o,
    input  resp_t                      mst_resp_i,
    output logic [4:0]                 busy_o
);

    aw_chan_t   aw_out;
    w_chan_t    w_out;
    b_chan_t    b_out;
    ar_chan_t   ar_out;
    r_chan_t    r_out;
    logic [4:0] in_ready;
    logic [4:0] out_valid;

    axi_delayer_cfg_stage #(.data_t(aw_chan_t), .DelayWidth(DelayWidth),
                            .Seed(LfsrSeed ^ 16'd1)) u_aw (
        .clk_i, .rst_ni, .mode(cfg_mode_i[0]), .delay(cfg_delay_i[0]),
        .in_valid(slv_req_i.aw_valid), .in_ready(in_ready[0]), .in_data(slv_req_i.aw),
        .out_valid(out_valid[0]), .out_ready(mst_resp_i.aw_ready), .out_data(aw_out),
        .busy(busy_o[0]));

    axi_delayer_cfg_stage #(.data_t(w_chan_t), .DelayWidth(DelayWidth),
                            .Seed(LfsrSeed ^ 16'd2)) u_w (
        .clk_i, .rst_ni, .mode(cfg_mode_i[1]), .delay(cfg_delay_i[1]),
        .in_valid(slv_req_i.w_valid), .in_ready(in_ready[1]), .in_data(slv_req_i.w),
        .out_valid(out_valid[1]), .out_ready(mst_resp_i.w_ready), .out_data(w_out),
        .busy(busy_o[1]));

    axi_delayer_cfg_stage #(.data_t(b_chan_t), .DelayWidth(DelayWidth),
                            .Seed(LfsrSeed ^ 16'd3)) u_b (
        .clk_i, .rst_ni, .mode(cfg_mode_i[2]), .delay(cfg_delay_i[2]),
        .in_valid(mst_resp_i.b_valid), .in_ready(in_ready[2]), .in_data(mst_resp_i.b),
        .out_valid(out_valid[2]), .out_ready(slv_req_i.b_ready), .out_data(b_out),
        .busy(busy_o[2]));

    axi_delayer_cfg_stage #(.data_t(ar_chan_t), .DelayWidth(DelayWidth),
                            .Seed(LfsrSeed ^ 16'd4)) u_ar (
        .clk_i, .rst_ni, .mode(cfg_mode_i[3]), .delay(cfg_delay_i[3]),
        .in_valid(slv_req_i.ar_valid), .in_ready(in_ready[3]), .in_data(slv_req_i.ar),
        .out_valid(out_valid[3]), .out_ready(mst_resp_i.ar_ready), .out_data(ar_out),
        .busy(busy_o[3]));

    axi_delayer_cfg_stage #(.data_t(r_chan_t), .DelayWidth(DelayWidth),
                            .Seed(LfsrSeed ^ 16'd5)) u_r (
        .clk_i, .rst_ni, .mode(cfg_mode_i[4]), .delay(cfg_delay_i[4]),
        .in_valid(mst_resp_i.r_valid), .in_ready(in_ready[4]), .in_data(mst_resp_i.r),
        .out_valid(out_valid[4]), .out_ready(slv_req_i.r_ready), .out_data(r_out),
        .busy(busy_o[4]));

    // Reassemble the request/response structs from the per-channel stages.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_out;
        mst_req_o.aw_valid = out_valid[0];
        mst_req_o.w        = w_out;
        mst_req_o.w_valid  = out_valid[1];
        mst_req_o.b_ready  = in_ready[2];
        mst_req_o.ar       = ar_out;
        mst_req_o.ar_valid = out_valid[3];
        mst_req_o.r_ready  = in_ready[4];

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = in_ready[0];
        slv_resp_o.w_ready  = in_ready[1];
        slv_resp_o.b        = b_out;
        slv_resp_o.b_valid  = out_valid[2];
        slv_resp_o.ar_ready = in_ready[3];
        slv_resp_o.r        = r_out;
        slv_resp_o.r_valid  = out_valid[4];
    end

endmodule
